// File: rtl/counter_ctrl.sv
// Sequencing controller for the 4-bit count datapath: accepts count commands,
// runs 0..limit one-shot or periodically, with pause/abort and registered status pulses.
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             aborted
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == PAUSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        limit_q    <= cmd_limit;
                        periodic_q <= cmd_periodic;
                        count      <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // abort beats pause beats counting; a tick due on an abort/pause edge is dropped
                    if (abort) begin
                        count   <= '0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else if (count == limit_q) begin
                        tick  <= 1'b1;
                        count <= '0;
                        if (!periodic_q) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                PAUSE: begin
                    // the resume edge only changes state; counting restarts on the following edge
                    if (abort) begin
                        count   <= '0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: hand-computed count/pulse sequences for
// one-shot, periodic, pause, abort, limit=0 and mid-run reset.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_limit = '0;
    logic       cmd_periodic = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       done;
    logic       aborted;

    int passed = 0;
    int total  = 0;

    counter_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_limit    (cmd_limit),
        .cmd_periodic (cmd_periodic),
        .pause        (pause),
        .abort        (abort),
        .count        (count),
        .busy         (busy),
        .tick         (tick),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            passed++;
    endtask

    // inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] lim, input logic per);
        cmd_valid    = 1'b1;
        cmd_limit    = lim;
        cmd_periodic = per;
        step();
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_count", count, 0);
        check("accept_ready", cmd_ready, 0);
    endtask

    initial begin
        // reset
        step();
        step();
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_pulses", {tick, done, aborted}, 3'b000);
        rst = 1'b0;

        // abort while idle is ignored
        abort = 1'b1;
        step();
        check("idle_abort", {aborted, busy}, 2'b00);
        abort = 1'b0;

        // one-shot, limit=3
        accept(4'd3, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("os3_count", count, k);
            check("os3_tick", tick, 0);
        end
        step();
        check("os3_end", {tick, done, busy, cmd_ready}, 4'b1101);
        check("os3_end_count", count, 0);

        // periodic, limit=2, nine cycles
        accept(4'd2, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step();
            check("per2_count", count, k % 3);
            check("per2_tick", tick, (k % 3) == 0);
            check("per2_done", done, 0);
            check("per2_busy", busy, 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("per2_abort", {aborted, busy, tick}, 3'b100);

        // one-shot, limit=5, pause 3 cycles at count=2; competing command held on cmd_valid
        accept(4'd5, 1'b0);
        step();
        step();
        check("pz_pre", count, 2);
        pause        = 1'b1;
        cmd_valid    = 1'b1;
        cmd_limit    = 4'd7;
        cmd_periodic = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("pz_hold", count, 2);
            check("pz_busy_ready", {busy, cmd_ready}, 2'b10);
        end
        pause = 1'b0;
        step();
        check("pz_resume", count, 2);
        for (int k = 3; k <= 5; k++) begin
            step();
            check("pz_count", count, k);
            check("pz_nodone", done, 0);
        end
        step();
        check("pz_end", {tick, done, busy, cmd_ready}, 4'b1101);
        // the held command is taken on the next edge; later cmd_limit changes must not matter
        step();
        cmd_valid = 1'b0;
        cmd_limit = 4'd1;
        check("held_accept", {busy, count}, {1'b1, 4'd0});
        for (int k = 1; k <= 7; k++) begin
            step();
            check("held_count", count, k);
        end
        step();
        check("held_end", {tick, done, busy}, 3'b110);

        // periodic, limit=4, abort at count=4 (tick due on the same edge is suppressed)
        accept(4'd4, 1'b1);
        for (int k = 1; k <= 4; k++) step();
        check("ab_pre", count, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_pulse", {aborted, tick, busy, cmd_ready}, 4'b1001);
        check("ab_count", count, 0);
        step();
        check("ab_single", aborted, 0);

        // limit=0 one-shot
        accept(4'd0, 1'b0);
        step();
        check("l0_end", {tick, done, busy, count}, {3'b110, 4'd0});

        // limit=0 periodic ticks every RUN cycle
        accept(4'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("l0p_tick", {tick, count, busy}, {1'b1, 4'd0, 1'b1});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;

        // reset mid-run at count=6 of limit=9, command held through reset
        accept(4'd9, 1'b0);
        for (int k = 1; k <= 6; k++) step();
        check("mr_pre", count, 6);
        rst          = 1'b1;
        cmd_valid    = 1'b1;
        cmd_limit    = 4'd15;
        cmd_periodic = 1'b0;
        step();
        check("mr_rst", {count, busy, tick, done, aborted}, {4'd0, 4'b0000});
        step();
        check("mr_noaccept", {busy, cmd_ready}, 2'b01);
        rst = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("mr_accept", {busy, count}, {1'b1, 4'd0});
        for (int k = 1; k <= 15; k++) begin
            step();
            check("full_count", count, k);
            check("full_tick", tick, 0);
        end
        step();
        check("full_end", {tick, done, busy, count}, {3'b110, 4'd0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencing controller for the 4-bit synchronous count datapath used in the coverage examples. It accepts count commands over a valid/ready interface and runs the count from 0 to a programmed limit, either one-shot or periodic. It supports pause and abort, and reports terminal-count ticks and completion. It sits between a stimulus/command source and the counter datapath. The counter register is owned internally so that the clear, enable and hold sequencing is fully defined here.

## Interface
- WIDTH, 4, count and limit width in bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  controller can accept a command; high only in IDLE
- cmd_limit  input  WIDTH  terminal value; count runs 0..cmd_limit inclusive
- cmd_periodic  input  1  0 = one-shot, 1 = auto-restart after each terminal count
- pause  input  1  level; holds count while high
- abort  input  1  level; terminates the active command
- count  output  WIDTH  current count value
- busy  output  1  high in RUN or PAUSE
- tick  output  1  one-cycle pulse, registered: terminal count reached
- done  output  1  one-cycle pulse, registered: one-shot completed normally
- aborted  output  1  one-cycle pulse, registered: command ended by abort

## Operation
- States: IDLE, RUN, PAUSE. The state register and limit/mode registers are internal.
- Reset, synchronous with highest priority: state=IDLE; count=0; busy=0; tick=0; done=0; aborted=0; limit and mode registers=0. All inputs are ignored while rst=1.
- cmd_ready = (state==IDLE), combinational. A command is accepted on a clock edge where cmd_valid && cmd_ready.
- IDLE:
  - On accept: latch cmd_limit and cmd_periodic, set count<=0, go to RUN.
  - pause and abort are ignored in IDLE.
- RUN, priority abort > pause > counting:
  - abort: go to IDLE, count<=0, aborted<=1.
  - else pause: go to PAUSE, count holds.
  - else if count==limit: tick<=1 and count<=0. Periodic mode stays in RUN. One-shot mode goes to IDLE and sets done<=1.
  - else count<=count+1.
- PAUSE:
  - abort: go to IDLE, count<=0, aborted<=1.
  - else if pause is low: return to RUN; count does not advance on that edge.
  - else remain in PAUSE with count held.
- tick, done and aborted default to 0 each cycle, so each is a single-cycle pulse.
- Arithmetic: count is unsigned, WIDTH bits. count never exceeds limit, so no natural wrap occurs. limit = 2^WIDTH-1 runs the full range.
- limit=0: count stays at 0, and tick fires every RUN cycle (periodic), or once with done (one-shot).
- cmd_valid while busy is not accepted: cmd_ready=0, and the command is neither queued nor dropped silently. The source must hold it.
- The limit and mode latched at acceptance are not affected by later changes on cmd_limit or cmd_periodic.

## Timing
- Accept at edge E0. After E0: busy=1, count=0, cmd_ready=0.
- With no pause, count=k after edge E0+k, for k ≤ limit.
- At edge E0+limit+1, tick=1 and count=0.
  - One-shot: done=1, busy=0 and cmd_ready=1 in that same cycle. A new command can be accepted on the next edge. Busy time is limit+1 cycles.
  - Periodic: tick repeats every limit+1 cycles.
- Pause sampled high at an edge: the count from before that edge is held. Each paused cycle extends the period by exactly one cycle, plus the one resume edge.
- Abort sampled at edge Ea: after Ea, state=IDLE, count=0, aborted=1. A tick due on the same edge is suppressed.
- Pause and terminal count on the same edge: pause wins, and the tick occurs on the first RUN edge after resuming.
- Reset mid-operation: all outputs take their reset values after the edge, and no done/aborted/tick pulse is generated.

## Test plan
- One-shot, limit=3: count 0,1,2,3 on successive cycles. Then tick=1, done=1, count=0, busy=0 at edge E0+4, with cmd_ready=1.
- Periodic, limit=2, run for 9 cycles: count sequence 0,1,2,0,1,2,0,1,2, with tick pulses at E0+3, E0+6 and E0+9. done is never asserted.
- One-shot, limit=5, pause high for 3 cycles while count=2: count holds at 2, and done arrives 4 cycles later than unpaused (E0+10). cmd_valid asserted during the run is not accepted.
- Periodic, limit=4, abort at count=4: aborted=1, tick=0, count=0, state IDLE. Next, a limit=0 one-shot gives tick=1 and done=1 at E0+1.
- rst asserted at count=6 of a limit=9 run: count=0, busy=0, and all pulses 0 after the edge. cmd_valid held with rst high is not accepted. After rst drops, the command is accepted and limit=15 counts 0..15 with a tick at E0+16.
